dmem_responder: RTL and testbench

Data-memory responder for the five-stage RISC-V core: the slave end of the core's `data_mem` port (chip-enable, write-enable, address, store data in; load data out). It holds a word-organised RAM and a small MMIO window with a cycle counter, store counter and `tohost` register. It also detects illegal stores and reports them through sticky fault outputs. It sits beside the instruction memory in the SoC/testbench top and is the reference target for software tests.

---
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 tb/tb_dmem_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory bus between the core's data_mem port (master) and the responder (slave).
// There is no handshake: data_ce_i qualifies an access, data_ce_i & data_we_i is a store that
// commits at the next rising edge, loads are combinational, and the slave never stalls.
interface dmem_responder_if;
    logic        data_ce_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (
        output data_ce_i,
        output data_we_i,
        output data_addr_i,
        output data_i,
        input  data_o
    );

    modport slave (
        input  data_ce_i,
        input  data_we_i,
        input  data_addr_i,
        input  data_i,
        output data_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Word RAM plus optional MMIO window (cycle/store counters, tohost, scratch) with sticky
// illegal-store reporting. The MMIO window is built only when DMEM_MMIO_EN is defined.
module dmem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic               clk,
    input  logic               rst,
    dmem_responder_if.slave    bus,
    output logic               fault_o,
    output logic [31:0]        fault_addr_o,
    output logic               done_o,
    output logic [31:0]        tohost_o
);
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

    logic [31:0] mem [DEPTH];

    logic          is_ram;
    logic          is_mmio;
    logic [AW-1:0] word_idx;
    logic          st;
    logic          aligned;
    logic          mmio_wr_ok;
    logic          legal;
    logic          illegal;
    logic          ram_we;
    logic [31:0]   mmio_rdata;
    logic [31:0]   rdata;

    logic          fault_q,      fault_d;
    logic [31:0]   fault_addr_q, fault_addr_d;

    assign is_ram   = bus.data_addr_i < RAM_BYTES;
    assign is_mmio  = bus.data_addr_i[31:5] == MMIO_BASE[31:5];
    assign word_idx = bus.data_addr_i[AW+1:2];
    assign st       = bus.data_ce_i & bus.data_we_i;
    assign aligned  = bus.data_addr_i[1:0] == 2'b00;
    assign legal    = st & aligned & (is_ram | (is_mmio & mmio_wr_ok));
    assign illegal  = st & ~legal;
    // Stores seen on an edge while rst is high must not reach the RAM either.
    assign ram_we   = legal & is_ram & ~rst;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[word_idx] <= bus.data_i;
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (bus.data_ce_i) begin
            if (is_ram) begin
                rdata = mem[word_idx];
            end else if (is_mmio) begin
                rdata = mmio_rdata;
            end
        end
    end
    assign bus.data_o = rdata;

    always_comb begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        if (illegal && !fault_q) begin
            fault_d      = 1'b1;
            fault_addr_d = bus.data_addr_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign fault_o      = fault_q;
    assign fault_addr_o = fault_addr_q;

`ifdef DMEM_MMIO_EN
    localparam logic [2:0] OFF_CYCLE_LO = 3'd0;
    localparam logic [2:0] OFF_CYCLE_HI = 3'd1;
    localparam logic [2:0] OFF_STORE_CNT = 3'd2;
    localparam logic [2:0] OFF_TOHOST   = 3'd3;
    localparam logic [2:0] OFF_SCRATCH  = 3'd4;

    logic [2:0]  mmio_off;
    logic [63:0] cycle_q,     cycle_d;
    logic [31:0] store_cnt_q, store_cnt_d;
    logic [31:0] tohost_q,    tohost_d;
    logic [31:0] scratch_q,   scratch_d;
    logic        done_q,      done_d;
    logic        wr_tohost;
    logic        wr_scratch;

    assign mmio_off   = bus.data_addr_i[4:2];
    assign mmio_wr_ok = (mmio_off == OFF_TOHOST) || (mmio_off == OFF_SCRATCH);
    assign wr_tohost  = legal & is_mmio & (mmio_off == OFF_TOHOST);
    assign wr_scratch = legal & is_mmio & (mmio_off == OFF_SCRATCH);

    always_comb begin
        mmio_rdata = 32'h0;
        case (mmio_off)
            OFF_CYCLE_LO:  mmio_rdata = cycle_q[31:0];
            OFF_CYCLE_HI:  mmio_rdata = cycle_q[63:32];
            OFF_STORE_CNT: mmio_rdata = store_cnt_q;
            OFF_TOHOST:    mmio_rdata = tohost_q;
            OFF_SCRATCH:   mmio_rdata = scratch_q;
            default:       mmio_rdata = 32'h0;
        endcase
    end

    always_comb begin
        cycle_d     = cycle_q + 64'd1;
        store_cnt_d = store_cnt_q;
        tohost_d    = tohost_q;
        scratch_d   = scratch_q;
        done_d      = done_q;
        if (legal) begin
            store_cnt_d = store_cnt_q + 32'd1;
        end
        if (wr_tohost) begin
            tohost_d = bus.data_i;
            // done is sticky: a later zero clears tohost only.
            if (bus.data_i != 32'h0) begin
                done_d = 1'b1;
            end
        end
        if (wr_scratch) begin
            scratch_d = bus.data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q     <= 64'h0;
            store_cnt_q <= 32'h0;
            tohost_q    <= 32'h0;
            scratch_q   <= 32'h0;
            done_q      <= 1'b0;
        end else begin
            cycle_q     <= cycle_d;
            store_cnt_q <= store_cnt_d;
            tohost_q    <= tohost_d;
            scratch_q   <= scratch_d;
            done_q      <= done_d;
        end
    end

    assign done_o   = done_q;
    assign tohost_o = tohost_q;
`else
    assign mmio_wr_ok = 1'b0;
    assign mmio_rdata = 32'h0;
    assign done_o     = 1'b0;
    assign tohost_o   = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; MMIO checks follow DMEM_MMIO_EN.
module tb_dmem_responder;
    localparam logic [31:0] MB = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fault_o;
    logic [31:0] fault_addr_o;
    logic        done_o;
    logic [31:0] tohost_o;

    int n_checks = 0;
    int n_pass   = 0;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH     (1024),
        .MMIO_BASE (MB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .fault_o      (fault_o),
        .fault_addr_o (fault_addr_o),
        .done_o       (done_o),
        .tohost_o     (tohost_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // driver: every bus change lands on a falling edge, then settles 1 time unit
    task automatic drive(input logic ce, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        @(negedge clk);
        bus.data_ce_i   = ce;
        bus.data_we_i   = we;
        bus.data_addr_i = addr;
        bus.data_i      = wdata;
        #1;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] wdata);
        drive(1'b1, 1'b1, addr, wdata);
    endtask

    task automatic do_read(input logic [31:0] addr);
        drive(1'b1, 1'b0, addr, 32'h0);
    endtask

    initial begin
        bus.data_ce_i   = 1'b0;
        bus.data_we_i   = 1'b0;
        bus.data_addr_i = 32'h0;
        bus.data_i      = 32'h0;

        // reset state
        @(negedge clk);
        #1;
        check("rst_fault", {31'h0, fault_o}, 32'h0);
        check("rst_fault_addr", fault_addr_o, 32'h0);
        check("rst_done", {31'h0, done_o}, 32'h0);
        check("rst_tohost", tohost_o, 32'h0);
        check("rst_data_o_idle", bus.data_o, 32'h0);

        // cycle counter: ten edges after deassertion
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        do_read(MB);
`ifdef DMEM_MMIO_EN
        check("cycle_lo_10", bus.data_o, 32'd10);
        bus.data_addr_i = MB + 32'h4;
        #1;
        check("cycle_hi_0", bus.data_o, 32'd0);
`else
        check("mmio_off_load0", bus.data_o, 32'd0);
`endif

        // RAM round trip
        do_store(32'h40, 32'hDEAD_BEEF);
        do_read(32'h40);
        check("ram_rt", bus.data_o, 32'hDEAD_BEEF);
        bus.data_addr_i = 32'h43;
        #1;
        check("ram_lowbits_ignored", bus.data_o, 32'hDEAD_BEEF);
        bus.data_ce_i = 1'b0;
        bus.data_addr_i = 32'h40;
        #1;
        check("ram_ce0_zero", bus.data_o, 32'h0);
        check("no_fault_after_legal", {31'h0, fault_o}, 32'h0);
`ifdef DMEM_MMIO_EN
        do_read(MB + 32'h8);
        check("store_cnt_1", bus.data_o, 32'd1);
`endif

        // last RAM word and first address past RAM
        do_store(32'hFFC, 32'hCAFE_0FFC);
        do_read(32'hFFC);
        check("ram_last_word", bus.data_o, 32'hCAFE_0FFC);
        do_read(32'h1000);
        check("past_ram_zero", bus.data_o, 32'h0);

        // misaligned store
        do_store(32'h42, 32'h1234_5678);
        check("fault_not_yet", {31'h0, fault_o}, 32'h0);
        do_read(32'h40);
        check("fault_set", {31'h0, fault_o}, 32'h1);
        check("fault_addr_42", fault_addr_o, 32'h42);
        check("ram_kept_40", bus.data_o, 32'hDEAD_BEEF);
`ifdef DMEM_MMIO_EN
        do_read(MB + 32'h8);
        check("store_cnt_unch", bus.data_o, 32'd2);
`endif
        do_store(32'h3000, 32'h5555_5555);
        do_read(32'h3000);
        check("fault_addr_sticky", fault_addr_o, 32'h42);
        check("unmapped_zero", bus.data_o, 32'h0);

        // read during write
        do_store(32'h80, 32'h11);
        do_store(32'h80, 32'h22);
        check("rdw_old", bus.data_o, 32'h11);
        do_read(32'h80);
        check("rdw_new", bus.data_o, 32'h22);

        // tohost / done
        do_store(MB + 32'hC, 32'h1);
        check("done_not_yet", {31'h0, done_o}, 32'h0);
        do_read(MB + 32'hC);
`ifdef DMEM_MMIO_EN
        check("done_set", {31'h0, done_o}, 32'h1);
        check("tohost_1", tohost_o, 32'h1);
        check("tohost_load", bus.data_o, 32'h1);
        do_store(MB + 32'hC, 32'h0);
        do_store(MB + 32'h10, 32'h0000_00A5);
        check("tohost_cleared", tohost_o, 32'h0);
        check("done_sticky", {31'h0, done_o}, 32'h1);
        do_read(MB + 32'h10);
        check("scratch_rt", bus.data_o, 32'hA5);
        bus.data_addr_i = MB + 32'h14;
        #1;
        check("mmio_unassigned0", bus.data_o, 32'h0);
        bus.data_addr_i = MB + 32'h8;
        #1;
        check("store_cnt_7", bus.data_o, 32'd7);
`else
        check("done_tied0", {31'h0, done_o}, 32'h0);
        check("tohost_tied0", tohost_o, 32'h0);
        check("tohost_load0", bus.data_o, 32'h0);
`endif

        // async reset, with a store held across an edge while reset is high
        do_store(32'h44, 32'h5555_AAAA);
        drive(1'b1, 1'b1, 32'h44, 32'h0000_0BAD);
        rst = 1'b1;
        #1;
        check("arst_fault", {31'h0, fault_o}, 32'h0);
        check("arst_fault_addr", fault_addr_o, 32'h0);
        check("arst_done", {31'h0, done_o}, 32'h0);
        check("arst_tohost", tohost_o, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.data_we_i = 1'b0;
        #1;
        check("rst_store_ignored", bus.data_o, 32'h5555_AAAA);
        do_read(32'h40);
        check("ram_survives_rst", bus.data_o, 32'hDEAD_BEEF);
`ifdef DMEM_MMIO_EN
        bus.data_addr_i = MB;
        #1;
        check("cycle_lo_after_rst", bus.data_o, 32'd1);
        bus.data_addr_i = MB + 32'h8;
        #1;
        check("store_cnt_rst", bus.data_o, 32'd0);
`endif

        // store to a read-only / unmapped MMIO word
        do_store(MB, 32'hFFFF_FFFF);
        do_read(MB);
        check("ro_store_fault", {31'h0, fault_o}, 32'h1);
        check("ro_store_addr", fault_addr_o, MB);
`ifndef DMEM_MMIO_EN
        check("mmio_base_load0", bus.data_o, 32'h0);
`endif

        drive(1'b0, 1'b0, 32'h0, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
